// File: rtl/dwt_pkg.sv
// Shared definitions for the DWT output path: coefficient width default, band codes
// and the subband buffer state encoding.
package dwt_pkg;

    localparam int DWT_DATA_W = 8;

    localparam logic BAND_L = 1'b0;
    localparam logic BAND_H = 1'b1;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_DRAIN_L = 2'd1,
        ST_DRAIN_H = 2'd2
    } buf_state_t;

endpackage

// File: rtl/dwt_band_ram.sv
// One band of frame storage: synchronous write, asynchronous read, no reset.
module dwt_band_ram #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 32,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dwt_subband_buffer.sv
// Captures one frame of (L,H) coefficient pairs, then replays all L followed by
// all H on a valid/ready stream for the band-wise quantiser.
module dwt_subband_buffer
    import dwt_pkg::*;
#(
    parameter int DATA_W    = DWT_DATA_W,
    parameter int FRAME_LEN = 32,
    parameter int ADDR_W    = $clog2(FRAME_LEN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] L_in,
    input  logic [DATA_W-1:0] H_in,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_band,
    output logic              out_last,
    output logic              overflow,
    input  logic              clr_ovf
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

    buf_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_idx, rd_idx;
    logic              wr_en, xfer, rd_at_last;
    logic [DATA_W-1:0] l_rd, h_rd;

    dwt_band_ram #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) L_mem (
        .clk(clk), .we(wr_en), .waddr(wr_idx), .wdata(L_in), .raddr(rd_idx), .rdata(l_rd)
    );

    dwt_band_ram #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) H_mem (
        .clk(clk), .we(wr_en), .waddr(wr_idx), .wdata(H_in), .raddr(rd_idx), .rdata(h_rd)
    );

    assign rd_at_last = (rd_idx == LAST_IDX);
    assign xfer       = out_valid && out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_FILL;
            wr_idx <= '0;
            rd_idx <= '0;
        end else begin
            state <= state_nxt;
            if (wr_en) wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            // Wrapping at the end of each band also leaves rd_idx at 0 for the next frame.
            if (xfer)  rd_idx <= rd_at_last ? '0 : rd_idx + 1'b1;
        end
    end

    // Outputs decode only from state, rd_idx and memory contents.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        out_valid = 1'b0;
        out_band  = BAND_L;
        out_last  = 1'b0;
        out_data  = '0;
        case (state)
            ST_FILL: begin
                in_ready = 1'b1;
                wr_en    = in_valid;
                if (in_valid && wr_idx == LAST_IDX) state_nxt = ST_DRAIN_L;
            end
            ST_DRAIN_L: begin
                out_valid = 1'b1;
                out_data  = l_rd;
                if (out_ready && rd_at_last) state_nxt = ST_DRAIN_H;
            end
            ST_DRAIN_H: begin
                out_valid = 1'b1;
                out_band  = BAND_H;
                out_data  = h_rd;
                out_last  = rd_at_last;
                if (out_ready && rd_at_last) state_nxt = ST_FILL;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    overflow <= 1'b0;
        else if (in_valid && !in_ready) overflow <= 1'b1;
        else if (clr_ovf)              overflow <= 1'b0;
    end

endmodule

// File: tb/tb_dwt_subband_buffer.sv
// Bench for dwt_subband_buffer: table of frames fed in, L-then-H replay checked
// against a scoreboard queue, plus hand sequences for stall, overflow and reset.
module tb_dwt_subband_buffer;
    localparam int FL = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready, clr_ovf;
    logic [DW-1:0] l_in, h_in;
    logic          in_ready, out_valid, out_band, out_last, overflow;
    logic [DW-1:0] out_data;

    dwt_subband_buffer #(.DATA_W(DW), .FRAME_LEN(FL)) dut (
        .clk(clk), .reset(rst_n), .in_valid(in_valid), .L_in(l_in), .H_in(h_in),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_band(out_band), .out_last(out_last),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] h;
        int            gap;
        logic [DW-1:0] exp_l;
        logic [DW-1:0] exp_h;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          b;
        logic          last;
    } exp_t;

    vec_t tbl[20];
    exp_t exp_q[$];
    int   errs   = 0;
    int   checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Scoreboard: every accepted output must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.d));
                chk("out_band", 32'(out_band), 32'(e.b));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    task automatic feed_pair(input vec_t v);
        in_valid = 1'b0;
        repeat (v.gap) begin
            @(negedge clk);
            chk("no_early_valid", 32'(out_valid), 0);
            @(posedge clk); #1;
        end
        chk("fill_in_ready", 32'(in_ready), 1);
        in_valid = 1'b1;
        l_in     = v.l;
        h_in     = v.h;
        @(negedge clk);
        chk("fill_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic feed_frame(input int base);
        exp_t e;
        for (int i = 0; i < FL; i++) feed_pair(tbl[base + i]);
        for (int i = 0; i < FL; i++) begin
            e.d = tbl[base + i].exp_l; e.b = 1'b0; e.last = 1'b0;
            exp_q.push_back(e);
        end
        for (int i = 0; i < FL; i++) begin
            e.d = tbl[base + i].exp_h; e.b = 1'b1; e.last = (i == FL - 1);
            exp_q.push_back(e);
        end
        chk("first_valid", 32'(out_valid), 1);
        chk("drain_in_ready", 32'(in_ready), 0);
    endtask

    task automatic wait_drain(input int exp_cycles);
        int cnt = 0;
        while (exp_q.size() != 0 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 0);
        if (exp_cycles > 0) chk("drain_cycles", 32'(cnt), 32'(exp_cycles));
        chk("post_in_ready", 32'(in_ready), 1);
        chk("post_out_valid", 32'(out_valid), 0);
    endtask

    initial begin
        for (int i = 0; i < FL; i++) begin
            tbl[i]      = '{8'(10 + i), 8'(200 + i), 0, 8'(10 + i), 8'(200 + i)};
            tbl[4 + i]  = '{8'(20 + i), 8'(40 + i),  0, 8'(20 + i), 8'(40 + i)};
            tbl[8 + i]  = '{8'(60 + i), 8'(160 + i), 2, 8'(60 + i), 8'(160 + i)};
            tbl[12 + i] = '{8'(30 + i), 8'(50 + i),  0, 8'(30 + i), 8'(50 + i)};
            tbl[16 + i] = '{8'(1 + i),  8'(5 + i),   0, 8'(1 + i),  8'(5 + i)};
        end

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_ovf = 1'b0;
        l_in = '0; h_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic reorder, ready held high: 2*FL drain cycles with no bubble.
        feed_frame(0);
        wait_drain(2 * FL);

        // Backpressure while presenting the second L coefficient.
        feed_frame(0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_data", 32'(out_data), 11);
            chk("stall_band", 32'(out_band), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_drain(-1);

        // Overflow set/clear with the drain stalled.
        out_ready = 1'b0;
        feed_frame(4);
        in_valid = 1'b1; l_in = 8'd99; h_in = 8'd99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_data_kept", 32'(out_data), 20);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        clr_ovf = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0; in_valid = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 1);
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("ovf_clr2", 32'(overflow), 0);
        out_ready = 1'b1;
        wait_drain(2 * FL);

        // Gapped input: idle cycles only stall the write index.
        feed_frame(8);
        wait_drain(2 * FL);

        // Reset while H index 1 is presented.
        feed_frame(12);
        repeat (FL + 1) begin
            @(posedge clk); #1;
        end
        chk("pre_rst_data", 32'(out_data), 51);
        chk("pre_rst_band", 32'(out_band), 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_in_ready", 32'(in_ready), 1);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_band", 32'(out_band), 0);
        chk("mid_rst_last", 32'(out_last), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        feed_frame(16);
        wait_drain(2 * FL);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dwt_subband_buffer.md
# dwt_subband_buffer

Downstream companion to the DWT `TOP`. It captures the per-cycle low-band (L) and high-band (H) coefficient pairs the transform produces and stores one frame of FRAME_LEN pairs. It then replays the frame band-sequentially (all L coefficients, then all H coefficients) on a valid/ready stream. The output feeds the band-wise quantiser/packer stage.

## Interface
- `DATA_W`, default 8: coefficient width; matches the DWT `L_out`/`H_out` width.
- `FRAME_LEN`, default 32: coefficient pairs per frame; must be ≥ 2.
- `ADDR_W`, default `$clog2(FRAME_LEN)`: derived; do not override.

- `clk`  in  1  system clock; single clock domain, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `L_in`/`H_in` hold a valid pair this cycle.
- `L_in`  in  DATA_W  low-band coefficient.
- `H_in`  in  DATA_W  high-band coefficient.
- `in_ready`  out  1  buffer accepts a pair this cycle.
- `out_data`  out  DATA_W  coefficient being presented.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `out_band`  out  1  band of `out_data`: 0 = L, 1 = H.
- `out_last`  out  1  final H coefficient of the frame.
- `overflow`  out  1  sticky flag: a pair was offered while `in_ready` was 0.
- `clr_ovf`  in  1  synchronous clear for `overflow`.

## Operation
- FSM states: FILL, DRAIN_L, DRAIN_H. Reset state is FILL with `wr_idx` = 0 and `rd_idx` = 0.
- FILL:
  - `in_ready` = 1.
  - On `in_valid`, write `L_in` to `L_mem[wr_idx]` and `H_in` to `H_mem[wr_idx]`, then increment `wr_idx`.
  - Accepting with `wr_idx` == FRAME_LEN-1 moves to DRAIN_L, clears `wr_idx`, and sets `rd_idx` = 0.
- DRAIN_L:
  - `out_valid` = 1, `out_band` = 0, `out_data` = `L_mem[rd_idx]`.
  - A transfer occurs when `out_valid` && `out_ready`; each transfer increments `rd_idx`.
  - A transfer at `rd_idx` == FRAME_LEN-1 moves to DRAIN_H and sets `rd_idx` = 0.
- DRAIN_H:
  - Same as DRAIN_L with `out_band` = 1 and `out_data` = `H_mem[rd_idx]`.
  - `out_last` = 1 when `rd_idx` == FRAME_LEN-1.
  - A transfer at `rd_idx` == FRAME_LEN-1 returns to FILL.
- `in_ready` = 0 in both drain states. Pairs offered then are dropped, not stored, and set `overflow`.
- `overflow`: set when `in_valid` && !`in_ready`; cleared by `clr_ovf`. If set and clear happen in the same cycle, set wins.
- Coefficients pass through unmodified: no sign handling, no arithmetic.
- When `out_valid` = 0, drive `out_data`, `out_band`, and `out_last` to 0.
- Memories are not reset. Their contents are meaningful only after a full frame has been written.

## Timing
- Reset values of outputs: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_band` = 0, `out_last` = 0, `overflow` = 0.
- All outputs depend only on registered state and memory contents. There is no combinational path from `out_ready` or `in_valid` to any output.
- `out_valid` rises the cycle after the final FILL acceptance.
- While `out_valid` = 1 and `out_ready` = 0, `out_data`, `out_band`, and `out_last` hold stable.
- With `out_ready` held high, DRAIN_L to DRAIN_H has no bubble, and the cycle after the `out_last` transfer shows `in_ready` = 1.
- Minimum frame period is 3·FRAME_LEN cycles: FRAME_LEN fill cycles plus 2·FRAME_LEN drain cycles.
- `in_valid` gaps during FILL simply stall `wr_idx`. Partial frames are never drained.
- A reset assertion mid-frame, in any state, discards the frame. The FSM returns to FILL with both indices at 0 and all outputs at their reset values.

## Structure
- Shared package `dwt_pkg` holds:
  - the `DATA_W` default (8);
  - the band constants `BAND_L` = 1'b0 and `BAND_H` = 1'b1;
  - the state enum `{ST_FILL, ST_DRAIN_L, ST_DRAIN_H}`.
- One sub-module, `dwt_band_ram` (parameters DATA_W and FRAME_LEN; one synchronous write port; one asynchronous read port; no reset). It is instantiated twice, once as `L_mem` and once as `H_mem`.
- The FSM, indices, and overflow flag live in the top of this block.

## Test plan
The bench uses FRAME_LEN = 4 and DATA_W = 8.
- **Reset state:** hold `reset` = 0 for 2 cycles → `in_ready` = 1, `out_valid` = 0, `overflow` = 0, `out_data` = 0.
- **Basic reorder:** feed pairs (L,H) = (10,200), (11,201), (12,202), (13,203) on consecutive cycles with `out_ready` = 1.
  - Output sequence is 10, 11, 12, 13 with `out_band` = 0, then 200, 201, 202, 203 with `out_band` = 1.
  - `out_last` = 1 only on 203; first `out_valid` appears 1 cycle after the 4th acceptance.
- **Backpressure:** same frame, `out_ready` low for 3 cycles while presenting 11 → `out_data` holds 11 for those cycles; the sequence is unchanged and has no duplicates.
- **Overflow:** assert `in_valid` with (99,99) during DRAIN_L.
  - `overflow` = 1 the next cycle; the drained data is unaffected.
  - `clr_ovf` pulse clears it; `clr_ovf` together with a new drop leaves it at 1.
- **Gapped input:** feed 4 pairs with 2 idle cycles between each → drain starts 1 cycle after the 4th acceptance; no output appears before then.
- **Reset mid-drain:** assert `reset` while presenting H index 1.
  - Outputs go to their reset values immediately.
  - A new frame (1,5), (2,6), (3,7), (4,8) then drains as 1, 2, 3, 4, 5, 6, 7, 8.
